ibex_data_mem_responder: RTL and testbench



---
 rtl/ibex_mem_resp_pkg.sv | 21 ++
 rtl/ibex_mem_resp_pipe.sv | 39 +++
 rtl/ibex_data_mem_responder.sv | 100 ++++++++++
 tb/tb_ibex_data_mem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and helpers for the req/gnt/rvalid memory responder.
package ibex_mem_resp_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_entry_t;

  localparam int unsigned ENTRY_W = $bits(resp_entry_t);

  // Upper bound formed in 33 bits so a window ending at 4 GiB does not wrap.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] words);
    logic [32:0] w_hi;
    w_hi = {1'b0, base} + (words << 2);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < w_hi);
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line; only the valid tags are cleared on reset.
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [ENTRY_W-1:0] o_entry
);

  resp_entry_t        w_in;
  logic [STAGES-1:0]  r_vld_p;
  logic [ENTRY_W-2:0] r_pay_p [STAGES];

  assign w_in = resp_entry_t'(i_entry);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_in.valid;
      for (int s = 1; s < STAGES; s++) begin
        r_vld_p[s] <= r_vld_p[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_pay_p[0] <= {w_in.err, w_in.rdata};
    for (int s = 1; s < STAGES; s++) begin
      r_pay_p[s] <= r_pay_p[s-1];
    end
  end

  assign o_entry = {r_vld_p[STAGES-1], r_pay_p[STAGES-1]};

endmodule

// File: rtl/ibex_data_mem_responder.sv
// Word-organised memory behind an Ibex-style req/gnt/rvalid port with
// byte-enabled writes, fixed response latency and bounded outstanding count.
module ibex_data_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_i,
  output logic                                 gnt_o,
  input  logic                                 we_i,
  input  logic [3:0]                           be_i,
  input  logic [31:0]                          addr_i,
  input  logic [31:0]                          wdata_i,
  output logic                                 rvalid_o,
  output logic [31:0]                          rdata_o,
  output logic                                 err_o,
  input  logic                                 stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned     IDX_W   = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      r_mem [MEM_WORDS];
  logic [CNT_W-1:0] r_cnt;

  logic             w_gnt;
  logic             w_err;
  logic             w_rvalid;
  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic             w_unused_offset;
  resp_entry_t      w_entry_p0;
  resp_entry_t      w_entry_out;

  // Held low through reset so nothing is accepted while the pipe is clearing.
  assign w_gnt = rst_ni & req_i & ~stall_i & (r_cnt < MAX_CNT);
  assign gnt_o = w_gnt;

  assign w_err    = ~in_range(addr_i, BASE_ADDR, 33'(MEM_WORDS)) | (addr_i[1:0] != 2'b00);
  assign w_offset = addr_i - BASE_ADDR;
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_unused_offset = ^{w_offset[31:IDX_W+2], w_offset[1:0]};

  always_ff @(posedge clk_i) begin
    if (w_gnt && we_i && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // p0: response entry formed in the grant cycle
  always_comb begin
    w_entry_p0.valid = w_gnt;
    w_entry_p0.err   = w_gnt & w_err;
    w_entry_p0.rdata = (w_gnt & ~we_i & ~w_err) ? w_rword : 32'h0;
  end

  ibex_mem_resp_pipe #(
    .STAGES (RESP_LATENCY)
  ) u_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_entry (w_entry_p0),
    .o_entry (w_entry_out)
  );

  // pipe output: response returned RESP_LATENCY cycles after grant
  assign w_rvalid = w_entry_out.valid;
  assign rvalid_o = w_rvalid;
  assign rdata_o  = w_rvalid ? w_entry_out.rdata : 32'h0;
  assign err_o    = w_rvalid & w_entry_out.err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_gnt && !w_rvalid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_gnt && w_rvalid) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign outstanding_o = r_cnt;

  a_cnt_bounds: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_cnt <= MAX_CNT) && !(w_rvalid && (r_cnt == '0)));

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Bench for ibex_data_mem_responder: latency-1 instance for data checks,
// latency-2 instance for throughput and mid-operation reset.
module tb_ibex_data_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        a_req, a_gnt, a_we, a_rvalid, a_err, a_stall;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_outst;
  logic        b_req, b_gnt, b_we, b_rvalid, b_err, b_stall;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_outst;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  ibex_data_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we),
    .be_i(a_be), .addr_i(a_addr), .wdata_i(a_wdata), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata), .err_o(a_err), .stall_i(a_stall), .outstanding_o(a_outst)
  );

  ibex_data_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LATENCY(2), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we),
    .be_i(b_be), .addr_i(b_addr), .wdata_i(b_wdata), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .err_o(b_err), .stall_i(b_stall), .outstanding_o(b_outst)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_rvalid !== 1'b0) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_rvalid", a_rvalid, 0);
        end else begin
          ea = qa.pop_front();
          chk("a_rdata", a_rdata, ea.rdata);
          chk("a_err", a_err, ea.err);
          chk("a_latency", cyc - ea.cyc, 1);
        end
      end else begin
        chk("a_idle_rdata", a_rdata, 0);
        chk("a_idle_err", a_err, 0);
      end
      chk("a_outst_le_max", a_outst > 2'd2, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b_rvalid !== 1'b0) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_rvalid", b_rvalid, 0);
        end else begin
          eb = qb.pop_front();
          chk("b_rdata", b_rdata, eb.rdata);
          chk("b_err", b_err, eb.err);
          chk("b_latency", cyc - eb.cyc, 2);
        end
      end else begin
        chk("b_idle_rdata", b_rdata, 0);
        chk("b_idle_err", b_err, 0);
      end
      chk("b_outst_le_max", b_outst > 2'd2, 0);
    end
  end

  task automatic set_in(input bit sel_b, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    if (sel_b) begin
      b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic push_exp(input bit sel_b, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.err = err; e.rdata = rdata; e.cyc = cyc;
    if (sel_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Entered and left at posedge+1; req stays high after return for back-to-back use.
  task automatic issue(input bit sel_b, input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
    bit done;
    int waits;
    logic g;
    done = 0;
    waits = 0;
    set_in(sel_b, 1'b1, we, be, addr, wdata);
    while (!done) begin
      @(negedge clk);
      g = sel_b ? b_gnt : a_gnt;
      if (g === 1'b1) begin
        push_exp(sel_b, exp_err, exp_rdata);
        done = 1;
      end else if (waits >= 20) begin
        chk("grant_timeout", g, 1);
        done = 1;
      end
      waits++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input bit sel_b, input int n);
    set_in(sel_b, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    int   ngr;
    int   k;

    vecs[0]  = '{1'b1, 4'hF, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'h5, 32'h10,        32'hAABBCCDD, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'hF, 32'h10,        32'h0,        1'b0, 32'hDEBBBEDD};
    vecs[4]  = '{1'b0, 4'hF, 32'h1000,      32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'hF, 32'h12,        32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 32'h0,         32'h55667788, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, 32'h1000,      32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'h0,         32'h0,        1'b0, 32'h55667788};
    vecs[9]  = '{1'b1, 4'hF, 32'h14,        32'h0BADF00D, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 32'h14,        32'h12345678, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'hF, 32'h14,        32'h0,        1'b0, 32'h0BADF00D};
    vecs[12] = '{1'b1, 4'hF, 32'hFFC,       32'hCAFEF00D, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'hF, 32'hFFC,       32'h0,        1'b0, 32'hCAFEF00D};
    vecs[14] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,        1'b1, 32'h0};
    vecs[15] = '{1'b1, 4'h3, 32'h11,        32'h99999999, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 4'hF, 32'h10,        32'h0,        1'b0, 32'hDEBBBEDD};

    rst_n   = 1'b0;
    a_stall = 1'b0;
    b_stall = 1'b0;
    set_in(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_in(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_outst", a_outst, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_b_outst", b_outst, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1, 0);
    idle(0, 2);

    for (int i = 0; i < 17; i++) begin
      issue(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
    end
    idle(0, 3);

    // stall holds off the grant until the cycle it drops
    a_stall = 1'b1;
    set_in(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_gnt", a_gnt, 0);
      @(posedge clk);
      #1;
    end
    a_stall = 1'b0;
    @(negedge clk);
    chk("stall_release_gnt", a_gnt, 1);
    if (a_gnt === 1'b1) push_exp(0, 1'b0, 32'h55667788);
    @(posedge clk);
    #1;
    idle(0, 3);

    for (int i = 0; i < 10; i++) begin
      issue(1, 1'b1, 4'hF, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 32'h0);
    end
    idle(1, 4);

    // latency 2 with two slots: two grants, then one cycle waiting for a slot
    ngr = 0;
    k = 0;
    set_in(1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    while (ngr < 10 && k < 40) begin
      @(negedge clk);
      chk("tp_gnt", b_gnt, (k % 3) != 2);
      if (k == 2) chk("tp_outst_full", b_outst, 2);
      if (b_gnt === 1'b1) begin
        push_exp(1, 1'b0, 32'h1000_0000 + 32'(ngr));
        ngr++;
      end
      @(posedge clk);
      #1;
      b_addr = 32'h40 + 32'(4 * ngr);
      k++;
    end
    chk("tp_grant_count", ngr, 10);
    idle(1, 4);

    issue(1, 1'b1, 4'hF, 32'h20, 32'h0000_1234, 1'b0, 32'h0);
    idle(1, 4);
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h1000_0000);
    issue(1, 1'b0, 4'hF, 32'h44, 32'h0, 1'b0, 32'h1000_0001);
    set_in(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    qb.delete();
    @(negedge clk);
    chk("pre_reset_outst", b_outst, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outst", b_outst, 0);
    chk("post_reset_rvalid", b_rvalid, 0);
    @(posedge clk);
    #1;
    idle(1, 4);
    issue(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h0000_1234);
    idle(1, 5);
    idle(0, 2);

    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
